slc3_stim_sequencer: RTL

SLC3_STIM_SEQUENCER -- requirements
Module: slc3_stim_sequencer

---
 rtl/slc3_stim_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/slc3_stim_sequencer.sv
// Table-driven stimulus sequencer: replays programmed switch/button steps and checks observed channels.
// Define STIM_FAILIDX_EN to capture the index of the first failing step on first_fail.
module slc3_stim_sequencer #(
    parameter int unsigned SW_W   = 10,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NCHK   = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DLY_W  = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CS_W   = $clog2(NCHK),
    localparam int unsigned STEP_W = 3 + CS_W + 2 + SW_W + DLY_W + DATA_W
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic                     prog_we,
    input  logic [PTR_W-1:0]         prog_addr,
    input  logic [STEP_W-1:0]        prog_data,
    input  logic [NCHK*DATA_W-1:0]   obs,
    output logic [SW_W-1:0]          SW,
    output logic                     Run,
    output logic                     Continue,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               err_cnt,
    output logic [PTR_W:0]           first_fail
);

    // Step word layout, LSB first: expected, delay, sw, cont_n, run_n, chk_sel, chk_en, last, spare
    localparam int unsigned DLY_LSB  = DATA_W;
    localparam int unsigned SW_LSB   = DLY_LSB + DLY_W;
    localparam int unsigned CONT_BIT = SW_LSB + SW_W;
    localparam int unsigned RUN_BIT  = CONT_BIT + 1;
    localparam int unsigned SEL_LSB  = RUN_BIT + 1;
    localparam int unsigned CHK_BIT  = SEL_LSB + CS_W;
    localparam int unsigned LAST_BIT = CHK_BIT + 1;
    localparam int unsigned TAB_W    = STEP_W - 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_DONE} state_t;
    state_t state_q, state_d;

    logic [TAB_W-1:0]  step_mem [DEPTH];
    logic [TAB_W-1:0]  cur;
    logic [DATA_W-1:0] obs_ch [NCHK];

    logic              cur_last, cur_chk, cur_run_n, cur_cont_n;
    logic [CS_W-1:0]   cur_sel;
    logic [SW_W-1:0]   cur_sw;
    logic [DLY_W-1:0]  cur_dly;
    logic [DATA_W-1:0] cur_exp;

    logic              in_run_c, start_acc_c, mismatch_c, unused_rsvd;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [7:0]        err_q, err_d;
    logic [SW_W-1:0]   sw_q, sw_d;
    logic              run_q, run_d, cont_q, cont_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    for (genvar k = 0; k < NCHK; k++) begin : g_obs
        assign obs_ch[k] = obs[k*DATA_W +: DATA_W];
    end

    assign unused_rsvd = prog_data[STEP_W-1];

    assign in_run_c    = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign start_acc_c = start && !in_run_c;

    assign cur        = step_mem[ptr_q];
    assign cur_last   = cur[LAST_BIT];
    assign cur_chk    = cur[CHK_BIT];
    assign cur_sel    = cur[SEL_LSB +: CS_W];
    assign cur_run_n  = cur[RUN_BIT];
    assign cur_cont_n = cur[CONT_BIT];
    assign cur_sw     = cur[SW_LSB +: SW_W];
    assign cur_dly    = cur[DLY_LSB +: DLY_W];
    assign cur_exp    = cur[0 +: DATA_W];

    // Table storage survives reset; writes are locked out while a table is running
    always_ff @(posedge Clk) begin
        if (prog_we && !in_run_c) begin
            step_mem[prog_addr] <= prog_data[TAB_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_FETCH;
            S_FETCH:        state_d = (cur_dly != '0) ? S_WAIT : S_CHECK;
            S_WAIT:         if (dly_q == DLY_W'(1)) state_d = S_CHECK;
            S_CHECK:        state_d = (cur_last || ptr_q == PTR_W'(DEPTH - 1)) ? S_DONE : S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        dly_d      = dly_q;
        err_d      = err_q;
        sw_d       = sw_q;
        run_d      = run_q;
        cont_d     = cont_q;
        mismatch_c = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ptr_d = '0;
                    err_d = '0;
                end
            end
            S_FETCH: begin
                sw_d   = cur_sw;
                run_d  = cur_run_n;
                cont_d = cur_cont_n;
                dly_d  = cur_dly;
            end
            S_WAIT: dly_d = dly_q - DLY_W'(1);
            S_CHECK: begin
                mismatch_c = cur_chk && (obs_ch[cur_sel] != cur_exp);
                if (mismatch_c && err_q != 8'hFF) err_d = err_q + 8'd1;
                if (state_d == S_FETCH) ptr_d = ptr_q + PTR_W'(1);
            end
            default: ;
        endcase
        if (state_d == S_DONE) begin
            run_d  = 1'b1;
            cont_d = 1'b1;
        end
        busy_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q  <= '0;
            dly_q  <= '0;
            err_q  <= '0;
            sw_q   <= '0;
            run_q  <= 1'b1;
            cont_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            dly_q  <= dly_d;
            err_q  <= err_d;
            sw_q   <= sw_d;
            run_q  <= run_d;
            cont_q <= cont_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

`ifdef STIM_FAILIDX_EN
    // All ones means no failure yet; ptr never reaches that value
    logic [PTR_W:0] ff_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ff_q <= '1;
        end else if (start_acc_c) begin
            ff_q <= '1;
        end else if (mismatch_c && (&ff_q)) begin
            ff_q <= {1'b0, ptr_q};
        end
    end

    assign first_fail = ff_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc_c;
    assign first_fail       = '1;
`endif

    assign SW       = sw_q;
    assign Run      = run_q;
    assign Continue = cont_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;

endmodule
